// File: rtl/pll_fb_divider_if.sv
// Control/status bundle between a PLL controller and the feedback divider.
// The controller drives enable and the ratio-load strobe; the divider returns the handshake and feedback edge.
interface pll_fb_divider_if #(
  parameter int WIDTH = 8
);
  logic             Enable;
  logic [WIDTH-1:0] Ndiv;
  logic             Load;
  logic             Ack;
  logic             TC;
  logic             FBout;

  modport master (
    output Enable,
    output Ndiv,
    output Load,
    input  Ack,
    input  TC,
    input  FBout
  );

  modport slave (
    input  Enable,
    input  Ndiv,
    input  Load,
    output Ack,
    output TC,
    output FBout
  );
endinterface

// File: rtl/pll_fb_divider.sv
// Integer-N feedback divider for the PLL loop: divides CLK by N and emits FBout for the PFD.
// A new N loaded through the Load/Ack handshake takes effect only at a period boundary.
module pll_fb_divider #(
  parameter int WIDTH     = 8,
  parameter int DEFAULT_N = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  pll_fb_divider_if.slave       bus
);

  localparam logic [WIDTH-1:0] N_RST = DEFAULT_N[WIDTH-1:0];
  localparam logic [WIDTH-1:0] N_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] ncur;
  logic [WIDTH-1:0] nshd;
  logic             pend;
  logic             fb_r;
  logic             tc_r;
  logic             ack_r;

  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] nnext;
  logic             reload;

  // Ratios below 2 cannot form a two-phase period, so they are raised to 2.
  function automatic logic [WIDTH-1:0] clamp_n(input logic [WIDTH-1:0] n);
    return (n < N_MIN) ? N_MIN : n;
  endfunction

  always_comb begin
    cnt_dec = cnt - ONE;
    nnext   = pend ? nshd : ncur;
    reload  = bus.Enable && (cnt == '0);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt   <= '0;
      ncur  <= N_RST;
      nshd  <= N_RST;
      pend  <= 1'b0;
      fb_r  <= 1'b0;
      tc_r  <= 1'b0;
      ack_r <= 1'b0;
    end else begin
      if (!bus.Enable) begin
        cnt   <= '0;
        fb_r  <= 1'b0;
        tc_r  <= 1'b0;
        ack_r <= 1'b0;
      end else if (reload) begin
        ncur  <= nnext;
        cnt   <= nnext - ONE;
        fb_r  <= 1'b1;
        tc_r  <= 1'b1;
        ack_r <= pend;
      end else begin
        cnt   <= cnt_dec;
        fb_r  <= (cnt_dec >= (ncur >> 1));
        tc_r  <= 1'b0;
        ack_r <= 1'b0;
      end

      // A load on a reload edge wins over the clear: the reload consumed the old shadow,
      // the fresh value waits for the next boundary.
      if (bus.Load) begin
        nshd <= clamp_n(bus.Ndiv);
        pend <= 1'b1;
      end else if (reload) begin
        pend <= 1'b0;
      end
    end
  end

  assign bus.FBout = fb_r;
  assign bus.TC    = tc_r;
  assign bus.Ack   = ack_r;

endmodule

// File: tb/tb_pll_fb_divider.sv
// Directed bench for pll_fb_divider: period/duty per ratio, load handshake, reset and enable.
module tb_pll_fb_divider;

  localparam int WIDTH = 8;

  logic CLK = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  pll_fb_divider_if #(.WIDTH(WIDTH)) bus ();

  pll_fb_divider #(.WIDTH(WIDTH), .DEFAULT_N(16)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int v);
    bus.Ndiv = v[WIDTH-1:0];
    bus.Load = 1'b1;
    tick();
    bus.Load = 1'b0;
  endtask

  task automatic wait_tc(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.TC && n < 600);
    if (!bus.TC) check({tag, "_timeout"}, 0, 1);
  endtask

  // Called on a TC sample; counts high/low samples up to the next TC.
  task automatic measure(input string tag, output int hi, output int lo, output int ack0);
    int n;
    hi = 0; lo = 0; n = 0;
    ack0 = int'(bus.Ack);
    do begin
      if (bus.FBout) hi++; else lo++;
      tick();
      n++;
    end while (!bus.TC && n < 600);
    if (!bus.TC) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic period(input string tag, input int ehi, input int elo, input int eack);
    int hi, lo, a;
    measure(tag, hi, lo, a);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_ack"}, a, eack);
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    bus.Enable = 1'b1;
    bus.Load = 1'b0;
    bus.Ndiv = '0;

    // Reset and default ratio of 16
    tick(); tick();
    Reset = 1'b0;
    check("rst_fb", int'(bus.FBout), 0);
    check("rst_tc", int'(bus.TC), 0);
    check("rst_ack", int'(bus.Ack), 0);
    tick();
    check("first_tc", int'(bus.TC), 1);
    check("first_fb", int'(bus.FBout), 1);
    check("first_ack", int'(bus.Ack), 0);
    period("n16a", 8, 8, 0);
    period("n16b", 8, 8, 0);

    // Mid-period load of 10 while running at 16
    repeat (6) tick();
    load(10);
    wait_tc("mid10", n);
    check("mid10_len", 7 + n, 16);
    check("mid10_ack", int'(bus.Ack), 1);
    period("n10a", 5, 5, 1);
    period("n10b", 5, 5, 0);

    // Two loads in one period: only the last survives
    load(10);
    tick();
    load(12);
    wait_tc("dbl", n);
    check("dbl_ack", int'(bus.Ack), 1);
    period("n12a", 6, 6, 1);
    period("n12b", 6, 6, 0);

    // Load of 5
    load(5);
    wait_tc("l5", n);
    check("l5_ack", int'(bus.Ack), 1);
    period("n5a", 3, 2, 1);
    period("n5b", 3, 2, 0);

    // Clamp of 0 and 1, then the maximum ratio
    load(0);
    wait_tc("l0", n);
    period("n0a", 1, 1, 1);
    period("n0b", 1, 1, 0);
    load(1);
    wait_tc("l1", n);
    period("n1a", 1, 1, 1);
    period("n1b", 1, 1, 0);
    load(255);
    wait_tc("l255", n);
    period("n255a", 128, 127, 1);

    // Reset discards a pending load
    load(10);
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("r2_fb", int'(bus.FBout), 0);
    check("r2_tc", int'(bus.TC), 0);
    check("r2_ack", int'(bus.Ack), 0);
    tick();
    check("r2_tc1", int'(bus.TC), 1);
    check("r2_ack1", int'(bus.Ack), 0);
    period("r2a", 8, 8, 0);
    period("r2b", 8, 8, 0);

    // Disable mid high phase, load while disabled, re-enable
    repeat (2) tick();
    check("en_hi", int'(bus.FBout), 1);
    bus.Enable = 1'b0;
    tick();
    check("dis_fb", int'(bus.FBout), 0);
    check("dis_tc", int'(bus.TC), 0);
    load(6);
    check("dis_fb2", int'(bus.FBout), 0);
    check("dis_ack", int'(bus.Ack), 0);
    bus.Enable = 1'b1;
    tick();
    check("reen_tc", int'(bus.TC), 1);
    check("reen_fb", int'(bus.FBout), 1);
    check("reen_ack", int'(bus.Ack), 1);
    period("n6a", 3, 3, 1);
    period("n6b", 3, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
